// File: rtl/instr_fetch_buffer_pkg.sv
// Shared fetch-buffer types: FSM encodings, PC step, buffered entry layout and PC helpers.
// The entry struct fixes the PC and instruction widths used by the fetch buffer and its FIFO.
package ifetch_pkg;

  localparam int IF_ADDR_W = 32;
  localparam int IF_DATA_W = 32;
  localparam logic [IF_ADDR_W-1:0] PC_STEP = 32'd4;

  typedef enum logic [1:0] {
    F_IDLE    = 2'd0,
    F_WAIT    = 2'd1,
    F_DISCARD = 2'd2
  } fetch_state_t;

  typedef struct packed {
    logic [IF_ADDR_W-1:0] pc;
    logic [IF_DATA_W-1:0] inst;
  } fetch_entry_t;

  function automatic logic [IF_ADDR_W-1:0] align_pc(input logic [IF_ADDR_W-1:0] addr);
    return {addr[IF_ADDR_W-1:2], 2'b00};
  endfunction

  function automatic logic [IF_ADDR_W-1:0] next_pc(input logic [IF_ADDR_W-1:0] pc);
    return pc + PC_STEP;
  endfunction

endpackage

// File: rtl/instr_fetch_buffer_if.sv
// Fetch-buffer bus: redirect input, instruction-memory req/ack, decode valid/ready, statistics.
// master = fetch buffer, slave = memory/decode/branch environment.
interface instr_fetch_buffer_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              redirect_valid;
  logic [ADDR_W-1:0] redirect_addr;
  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_ack;
  logic [DATA_W-1:0] mem_rdata;
  logic              inst_valid;
  logic [DATA_W-1:0] inst_data;
  logic [ADDR_W-1:0] inst_pc;
  logic              inst_ready;
  logic [31:0]       stat_fetched;
  logic [15:0]       stat_flushes;

  modport master (
    input  redirect_valid, redirect_addr, mem_ack, mem_rdata, inst_ready,
    output mem_req, mem_addr, inst_valid, inst_data, inst_pc, stat_fetched, stat_flushes
  );

  modport slave (
    output redirect_valid, redirect_addr, mem_ack, mem_rdata, inst_ready,
    input  mem_req, mem_addr, inst_valid, inst_data, inst_pc, stat_fetched, stat_flushes
  );
endinterface

// File: rtl/instr_fetch_buffer_fifo.sv
// Purpose: DEPTH-entry synchronous FIFO of fetch entries with flush and occupancy count.
// Latency: push visible at head the cycle after the write edge; no bypass.
// Backpressure: pop ignored when empty; caller guarantees no push when full.
module ifetch_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       push_vld,
  input  logic [WIDTH-1:0]           push_dat,
  input  logic                       pop_vld,
  input  logic                       flush,
  output logic [WIDTH-1:0]           head_dat,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       empty
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic [WIDTH-1:0] hold_q;
  logic             do_pop;

  assign empty  = (count_q == '0);
  assign do_pop = pop_vld && !empty;
  assign count  = count_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      hold_q   <= '0;
    end else begin
      // Head is shadowed every cycle so the output keeps its last value once drained or flushed.
      if (!empty) hold_q <= mem_q[rd_ptr_q];
      if (flush) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
        count_q  <= '0;
      end else begin
        if (push_vld) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
        if (do_pop)   rd_ptr_q <= rd_ptr_q + PTR_W'(1);
        count_q <= count_q + CNT_W'(push_vld) - CNT_W'(do_pop);
      end
    end
  end

  always_ff @(posedge clock) begin
    if (push_vld && !flush) mem_q[wr_ptr_q] <= push_dat;
  end

  assign head_dat = empty ? hold_q : mem_q[rd_ptr_q];

endmodule

// File: rtl/instr_fetch_buffer.sv
// Purpose: owns the fetch PC, reads instruction memory over req/ack, buffers {pc,inst} for decode.
// Latency: ack at an edge gives inst_valid the following cycle; 1 instr/cycle with zero-wait memory.
// Backpressure: a request is only issued with a free slot reserved; redirect flushes and refetches.
// Optional IFETCH_STATS_EN builds the fetched/flush counters; otherwise stat ports read 0.
// ADDR_W/DATA_W must match the ifetch_pkg entry widths.
module instr_fetch_buffer
  import ifetch_pkg::*;
#(
  parameter int              ADDR_W   = IF_ADDR_W,
  parameter int              DATA_W   = IF_DATA_W,
  parameter int              DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic                   clock,
  input  logic                   reset,
  instr_fetch_buffer_if.master   bus
);
  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  fetch_state_t      state_q, state_d;
  logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [CNT_W-1:0]  count, count_after;
  logic              fifo_empty, pop, push;
  fetch_entry_t      push_dat, head_dat;

  assign pop         = bus.inst_ready && !fifo_empty;
  assign count_after = count + CNT_W'(1) - CNT_W'(pop);
  assign push_dat    = '{pc: fetch_pc_q, inst: bus.mem_rdata};

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    mem_addr_d = mem_addr_q;
    push       = 1'b0;
    if (bus.redirect_valid) begin
      fetch_pc_d = align_pc(bus.redirect_addr);
      // A request already on the bus must still be acked before the new PC is issued.
      case (state_q)
        F_WAIT, F_DISCARD: state_d = bus.mem_ack ? F_IDLE : F_DISCARD;
        default:           state_d = F_IDLE;
      endcase
    end else begin
      case (state_q)
        F_IDLE: begin
          if (count < DEPTH_C) begin
            state_d    = F_WAIT;
            mem_addr_d = fetch_pc_q;
          end
        end
        F_WAIT: begin
          if (bus.mem_ack) begin
            push       = 1'b1;
            fetch_pc_d = next_pc(fetch_pc_q);
            if (count_after < DEPTH_C) mem_addr_d = next_pc(fetch_pc_q);
            else                       state_d    = F_IDLE;
          end
        end
        F_DISCARD: begin
          if (bus.mem_ack) state_d = F_IDLE;
        end
        default: state_d = F_IDLE;
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= F_IDLE;
      fetch_pc_q <= RESET_PC;
      mem_addr_q <= RESET_PC;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      mem_addr_q <= mem_addr_d;
    end
  end

  ifetch_fifo #(
    .WIDTH ($bits(fetch_entry_t)),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clock    (clock),
    .reset    (reset),
    .push_vld (push),
    .push_dat (push_dat),
    .pop_vld  (bus.inst_ready),
    .flush    (bus.redirect_valid),
    .head_dat (head_dat),
    .count    (count),
    .empty    (fifo_empty)
  );

  assign bus.mem_req    = (state_q != F_IDLE);
  assign bus.mem_addr   = mem_addr_q;
  assign bus.inst_valid = !fifo_empty;
  assign bus.inst_data  = head_dat.inst[DATA_W-1:0];
  assign bus.inst_pc    = head_dat.pc[ADDR_W-1:0];

`ifdef IFETCH_STATS_EN
  logic [31:0] fetched_q;
  logic [15:0] flushes_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      fetched_q <= '0;
      flushes_q <= '0;
    end else begin
      if (push)               fetched_q <= fetched_q + 32'd1;
      if (bus.redirect_valid) flushes_q <= flushes_q + 16'd1;
    end
  end

  assign bus.stat_fetched = fetched_q;
  assign bus.stat_flushes = flushes_q;
`else
  assign bus.stat_fetched = '0;
  assign bus.stat_flushes = '0;
`endif

endmodule
